// File: rtl/top_level.sv
// top_level: single-cycle 8-bit register processor. It executes 9-bit instructions from a
// 256-entry program ROM against an 8x8 register file and a 256x8 data memory.

module pc_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] next_pc,
  output logic [7:0] PC
);
  // program counter, forced to 0 asynchronously while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PC <= 8'd0;
    else        PC <= next_pc;
  end
endmodule

module prog_rom (
  input  logic [7:0] addr,
  output logic [8:0] data
);
  logic [8:0] rom [0:255];
  assign data = rom[addr];
endmodule

module alu (
  input  logic [2:0] ALU_op_code,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] ALU_out
);
  // unary ops (shift, not, pass) act on operand b, which carries Rr for MISC
  always_comb begin
    ALU_out = b_in;
    case (ALU_op_code)
      3'd0:    ALU_out = a_in + b_in;
      3'd1:    ALU_out = a_in - b_in;
      3'd2:    ALU_out = a_in & b_in;
      3'd3:    ALU_out = a_in ^ b_in;
      3'd4:    ALU_out = {b_in[6:0], 1'b0};
      3'd5:    ALU_out = {1'b0, b_in[7:1]};
      3'd6:    ALU_out = ~b_in;
      default: ALU_out = b_in;
    endcase
  end
endmodule

module reg_file (
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);
  logic [7:0] registers [0:7];

  // single write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) registers[waddr] <= wdata;
  end

  assign rdata_a = registers[raddr_a];
  assign rdata_b = registers[raddr_b];
endmodule

module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] core [0:255];

  // synchronous write, asynchronous read; not cleared by reset
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];
endmodule

module top_level (
  input  logic CLK,
  input  logic start,
  output logic halt
);
  logic [8:0] Instruction;
  logic [7:0] pc_s, next_pc_s;
  logic [2:0] op_s, fa_s, fb_s;
  logic [2:0] alu_op_s, raddr_a_s, raddr_b_s, waddr_s;
  logic [7:0] rdata_a_s, rdata_b_s, alu_out_s, mem_rdata_s, wdata_s;
  logic       reg_we_s, mem_we_s, halt_s;

  pc_reg   PC1      (.clk(CLK), .rst_n(start), .next_pc(next_pc_s), .PC(pc_s));
  prog_rom rom1     (.addr(pc_s), .data(Instruction));
  alu      ALU1     (.ALU_op_code(alu_op_s), .a_in(rdata_a_s), .b_in(rdata_b_s),
                     .ALU_out(alu_out_s));
  reg_file reg_file1 (.clk(CLK), .we(reg_we_s & start), .waddr(waddr_s), .wdata(wdata_s),
                      .raddr_a(raddr_a_s), .raddr_b(raddr_b_s),
                      .rdata_a(rdata_a_s), .rdata_b(rdata_b_s));
  data_mem data_mem1 (.clk(CLK), .we(mem_we_s & start), .addr(rdata_b_s),
                      .wdata(rdata_a_s), .rdata(mem_rdata_s));

  assign op_s = Instruction[8:6];
  assign fa_s = Instruction[5:3];
  assign fb_s = Instruction[2:0];
  assign halt = halt_s & start;

  // decode: MISC reads R0 on port a and Rr on port b so branches and moves see both
  always_comb begin
    alu_op_s  = 3'd7;
    raddr_a_s = fa_s;
    raddr_b_s = fb_s;
    reg_we_s  = 1'b0;
    waddr_s   = fa_s;
    wdata_s   = alu_out_s;
    mem_we_s  = 1'b0;
    halt_s    = 1'b0;
    next_pc_s = pc_s + 8'd1;
    case (op_s)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        alu_op_s = op_s;
        reg_we_s = 1'b1;
      end
      3'b100: begin
        reg_we_s = 1'b1;
        wdata_s  = mem_rdata_s;
      end
      3'b101: mem_we_s = 1'b1;
      3'b110: begin
        reg_we_s = 1'b1;
        waddr_s  = 3'd0;
        wdata_s  = {2'b00, Instruction[5:0]};
      end
      3'b111: begin
        raddr_a_s = 3'd0;
        waddr_s   = fb_s;
        case (fa_s)
          3'b000: begin alu_op_s = 3'd4; reg_we_s = 1'b1; end
          3'b001: begin alu_op_s = 3'd5; reg_we_s = 1'b1; end
          3'b010: begin
            if (rdata_a_s != 8'd0) next_pc_s = rdata_b_s;
            else                   next_pc_s = pc_s + 8'd1;
          end
          3'b011: begin
            if (rdata_a_s == 8'd0) next_pc_s = rdata_b_s;
            else                   next_pc_s = pc_s + 8'd1;
          end
          3'b100: begin reg_we_s = 1'b1; wdata_s = rdata_a_s; end
          3'b101: begin reg_we_s = 1'b1; waddr_s = 3'd0; wdata_s = rdata_b_s; end
          3'b110: begin alu_op_s = 3'd6; reg_we_s = 1'b1; end
          default: begin
            halt_s    = 1'b1;
            next_pc_s = pc_s;
          end
        endcase
      end
      default: reg_we_s = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_top_level.sv
// Directed-program bench for top_level: programs and operands are loaded through the
// hierarchy, expectations go into a scoreboard queue and a monitor process compares them.
module tb_top_level;
  logic CLK = 1'b0;
  logic start = 1'b0;
  logic halt;

  top_level dut (.CLK(CLK), .start(start), .halt(halt));

  always #5 CLK = ~CLK;

  localparam int K_PC = 0, K_HALT = 1, K_REG = 2, K_MEM = 3;
  localparam logic [8:0] HALT_I = 9'b111_111_000;

  typedef struct {
    string name;
    int    kind;
    int    idx;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q [$];
  event     check_ev;
  int       vectors = 0;
  int       miscompares = 0;

  function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [8:0] ldi(input logic [5:0] v);
    return {3'b110, v};
  endfunction

  task automatic expect_val(input string name, input int kind, input int idx, input int exp);
    sb_item_t it;
    it.name = name; it.kind = kind; it.idx = idx; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic flush();
    -> check_ev;
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d items left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic begin_test();
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 256; i++) dut.rom1.rom[i] = HALT_I;
  endtask

  task automatic launch();
    @(negedge CLK);
    start = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load_loop();
    dut.rom1.rom[0] = ldi(6'd3);
    dut.rom1.rom[1] = ins(3'b111, 3'b100, 3'd2);   // MOVT R2 (loop address 3)
    dut.rom1.rom[2] = ldi(6'd3);
    dut.rom1.rom[3] = ins(3'b001, 3'd0, 3'd1);     // SUB R0,R1
    dut.rom1.rom[4] = ins(3'b000, 3'd6, 3'd1);     // ADD R6,R1 (iteration count)
    dut.rom1.rom[5] = ins(3'b111, 3'b010, 3'd2);   // BNZ R2
    dut.reg_file1.registers[1] = 8'd1;
    dut.reg_file1.registers[6] = 8'd0;
  endtask

  // monitor: pops each expectation when a check point is signalled and compares to the DUT
  initial begin : monitor
    sb_item_t it;
    int act;
    forever begin
      @(check_ev);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        case (it.kind)
          K_PC:    act = int'(dut.PC1.PC);
          K_HALT:  act = int'(halt);
          K_REG:   act = int'(dut.reg_file1.registers[it.idx[2:0]]);
          default: act = int'(dut.data_mem1.core[it.idx[7:0]]);
        endcase
        vectors++;
        if (act != it.exp) begin
          miscompares++;
          $display("FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // reset / launch
    begin_test();
    for (int i = 0; i < 256; i++) dut.data_mem1.core[i] = 8'd0;
    for (int i = 0; i < 8; i++) dut.reg_file1.registers[i] = 8'd0;
    dut.rom1.rom[0] = ldi(6'd5);
    #1;
    expect_val("reset_pc", K_PC, 0, 0);
    expect_val("reset_halt", K_HALT, 0, 0);
    flush();
    launch();
    run(1);
    expect_val("ldi_r0", K_REG, 0, 5);
    expect_val("ldi_halt", K_HALT, 0, 1);
    expect_val("ldi_pc", K_PC, 0, 1);
    flush();
    run(3);
    expect_val("halt_pc_holds", K_PC, 0, 1);
    expect_val("halt_stays", K_HALT, 0, 1);
    flush();

    // ALU wrap-around and logic ops
    begin_test();
    dut.reg_file1.registers[1] = 8'd200;
    dut.reg_file1.registers[2] = 8'd100;
    dut.reg_file1.registers[3] = 8'hF0;
    dut.reg_file1.registers[4] = 8'h3C;
    dut.reg_file1.registers[5] = 8'h77;
    dut.rom1.rom[0] = ins(3'b000, 3'd1, 3'd2);
    dut.rom1.rom[1] = ins(3'b001, 3'd2, 3'd1);
    dut.rom1.rom[2] = ins(3'b010, 3'd3, 3'd4);
    dut.rom1.rom[3] = ins(3'b011, 3'd4, 3'd3);
    dut.rom1.rom[4] = ins(3'b001, 3'd5, 3'd5);
    launch();
    run(6);
    expect_val("add_wrap_r1", K_REG, 1, 44);
    expect_val("sub_r2", K_REG, 2, 56);
    expect_val("and_r3", K_REG, 3, 8'h30);
    expect_val("xor_r4", K_REG, 4, 8'h0C);
    expect_val("sub_self_r5", K_REG, 5, 0);
    expect_val("alu_pc", K_PC, 0, 5);
    expect_val("alu_halt", K_HALT, 0, 1);
    flush();

    // memory store then immediate load
    begin_test();
    dut.data_mem1.core[7] = 8'd0;
    dut.rom1.rom[0] = ldi(6'd42);
    dut.rom1.rom[1] = ins(3'b111, 3'b100, 3'd3);
    dut.rom1.rom[2] = ldi(6'd7);
    dut.rom1.rom[3] = ins(3'b101, 3'd3, 3'd0);
    dut.rom1.rom[4] = ins(3'b100, 3'd4, 3'd0);
    launch();
    run(6);
    expect_val("movt_r3", K_REG, 3, 42);
    expect_val("ldr_r4", K_REG, 4, 42);
    expect_val("mem7", K_MEM, 7, 42);
    expect_val("mem_r0", K_REG, 0, 7);
    expect_val("mem_pc", K_PC, 0, 5);
    flush();

    // countdown loop with BNZ
    begin_test();
    load_loop();
    launch();
    run(11);
    expect_val("loop_not_done_halt", K_HALT, 0, 0);
    expect_val("loop_not_done_pc", K_PC, 0, 5);
    flush();
    run(1);
    expect_val("loop_r0", K_REG, 0, 0);
    expect_val("loop_iters", K_REG, 6, 3);
    expect_val("loop_halt", K_HALT, 0, 1);
    expect_val("loop_pc", K_PC, 0, 6);
    flush();

    // shifts, NOT, MOVF and BZ
    begin_test();
    dut.reg_file1.registers[5] = 8'h81;
    dut.reg_file1.registers[7] = 8'd9;
    dut.rom1.rom[0] = ins(3'b111, 3'b000, 3'd5);
    dut.rom1.rom[1] = ins(3'b111, 3'b001, 3'd5);
    dut.rom1.rom[2] = ins(3'b111, 3'b110, 3'd5);
    dut.rom1.rom[3] = ins(3'b111, 3'b101, 3'd5);
    dut.rom1.rom[4] = ins(3'b111, 3'b011, 3'd7);
    dut.rom1.rom[5] = ldi(6'd0);
    dut.rom1.rom[6] = ins(3'b111, 3'b011, 3'd7);
    dut.rom1.rom[7] = ldi(6'd1);
    launch();
    run(1); expect_val("shl_r5", K_REG, 5, 8'h02); flush();
    run(1); expect_val("shr_r5", K_REG, 5, 8'h01); flush();
    run(1); expect_val("not_r5", K_REG, 5, 8'hFE); flush();
    run(1); expect_val("movf_r0", K_REG, 0, 8'hFE); flush();
    run(1); expect_val("bz_not_taken_pc", K_PC, 0, 5); flush();
    run(2);
    expect_val("bz_taken_pc", K_PC, 0, 9);
    expect_val("bz_r0", K_REG, 0, 0);
    expect_val("bz_halt", K_HALT, 0, 1);
    flush();

    // mid-run reset
    begin_test();
    load_loop();
    launch();
    run(5);
    #2;
    start = 1'b0;
    #1;
    expect_val("midrst_pc", K_PC, 0, 0);
    expect_val("midrst_halt", K_HALT, 0, 0);
    expect_val("midrst_r0_kept", K_REG, 0, 2);
    expect_val("midrst_r6_kept", K_REG, 6, 1);
    flush();
    run(1);
    expect_val("rst_edge_no_write", K_REG, 0, 2);
    expect_val("rst_edge_pc", K_PC, 0, 0);
    flush();
    launch();
    run(1);
    expect_val("restart_pc", K_PC, 0, 1);
    expect_val("restart_r0", K_REG, 0, 3);
    flush();

    // HALT at address 0: halt gated by reset, no writes once halted
    begin_test();
    dut.reg_file1.registers[0] = 8'h11;
    #1;
    expect_val("halt0_in_reset", K_HALT, 0, 0);
    flush();
    launch();
    #1;
    expect_val("halt0_released", K_HALT, 0, 1);
    flush();
    run(2);
    expect_val("halt0_pc", K_PC, 0, 0);
    expect_val("halt0_r0", K_REG, 0, 8'h11);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
